// File: rtl/alu_decode_queue_pkg.sv
// Shared RISC-V ALU decode definitions: ALU operation classes, AMO
// sub-operations and ALU control codes, including the Zbb codes
// (ANDN/ORN/XNOR/MIN/MAX/...) used by the optional RV_ZBB_EN decode.
package alu_decode_queue_pkg;

    localparam int ALU_OP_WIDTH   = 3;
    localparam int AMO_OP_WIDTH   = 4;
    localparam int ALU_CTRL_WIDTH = 5;

    // Code 7 is deliberately unassigned.
    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_OP_ADD         = 3'd0,
        ALU_OP_SUB         = 3'd1,
        ALU_OP_AUIPC       = 3'd2,
        ALU_OP_LUI         = 3'd3,
        ALU_OP_BRANCH      = 3'd4,
        ALU_OP_ARITH_LOGIC = 3'd5,
        ALU_OP_AMO         = 3'd6
    } alu_op_e;

    // Codes 11..15 are deliberately unassigned.
    typedef enum logic [AMO_OP_WIDTH-1:0] {
        AMO_ADD  = 4'd0,
        AMO_SWAP = 4'd1,
        AMO_LR   = 4'd2,
        AMO_SC   = 4'd3,
        AMO_XOR  = 4'd4,
        AMO_AND  = 4'd5,
        AMO_OR   = 4'd6,
        AMO_MIN  = 4'd7,
        AMO_MAX  = 4'd8,
        AMO_MINU = 4'd9,
        AMO_MAXU = 4'd10
    } amo_op_e;

    typedef enum logic [ALU_CTRL_WIDTH-1:0] {
        ALU_CTRL_ADD_ADDI   = 5'd0,
        ALU_CTRL_SUB        = 5'd1,
        ALU_CTRL_AUIPC      = 5'd2,
        ALU_CTRL_LUI        = 5'd3,
        ALU_CTRL_BEQ        = 5'd4,
        ALU_CTRL_BNE        = 5'd5,
        ALU_CTRL_BLT        = 5'd6,
        ALU_CTRL_BGE        = 5'd7,
        ALU_CTRL_BLTU       = 5'd8,
        ALU_CTRL_BGEU       = 5'd9,
        ALU_CTRL_SLL_SLLI   = 5'd10,
        ALU_CTRL_SLT_SLTI   = 5'd11,
        ALU_CTRL_SLTU_SLTIU = 5'd12,
        ALU_CTRL_XOR_XORI   = 5'd13,
        ALU_CTRL_OR_ORI     = 5'd14,
        ALU_CTRL_AND_ANDI   = 5'd15,
        ALU_CTRL_SRL_SRLI   = 5'd16,
        ALU_CTRL_SRA_SRAI   = 5'd17,
        ALU_CTRL_MIN        = 5'd18,
        ALU_CTRL_MAX        = 5'd19,
        ALU_CTRL_MINU       = 5'd20,
        ALU_CTRL_MAXU       = 5'd21,
        ALU_CTRL_ANDN       = 5'd22,
        ALU_CTRL_ORN        = 5'd23,
        ALU_CTRL_XNOR       = 5'd24
    } alu_ctrl_e;

endpackage

// File: rtl/alu_decode_queue_core.sv
// Combinational ALU control decoder.
// Inputs : aluop, amoop, funct3, funct7, op_bit5, imm_bit10
// Outputs: alu_ctrl (ALU control code), illegal (undefined encoding seen)
// Macro  : RV_ZBB_EN adds the Zbb MIN/MINU/MAX/MAXU/ANDN/ORN/XNOR decodes.
// Undefined encodings fall back to ADD_ADDI with illegal set, so no X escapes.
module alu_decode_queue_core
    import alu_decode_queue_pkg::*;
(
    input  logic [ALU_OP_WIDTH-1:0]   aluop,
    input  logic [AMO_OP_WIDTH-1:0]   amoop,
    input  logic [2:0]                funct3,
    input  logic [6:0]                funct7,
    input  logic                      op_bit5,
    input  logic                      imm_bit10,
    output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
    output logic                      illegal
);

`ifndef RV_ZBB_EN
    // Only funct7[5] matters for the base decode.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};
`endif

    always_comb begin
        alu_ctrl = ALU_CTRL_ADD_ADDI;
        illegal  = 1'b0;
        case (aluop)
            ALU_OP_ADD:   alu_ctrl = ALU_CTRL_ADD_ADDI;
            ALU_OP_SUB:   alu_ctrl = ALU_CTRL_SUB;
            ALU_OP_AUIPC: alu_ctrl = ALU_CTRL_AUIPC;
            ALU_OP_LUI:   alu_ctrl = ALU_CTRL_LUI;
            ALU_OP_BRANCH: begin
                case (funct3)
                    3'b000:  alu_ctrl = ALU_CTRL_BEQ;
                    3'b001:  alu_ctrl = ALU_CTRL_BNE;
                    3'b100:  alu_ctrl = ALU_CTRL_BLT;
                    3'b101:  alu_ctrl = ALU_CTRL_BGE;
                    3'b110:  alu_ctrl = ALU_CTRL_BLTU;
                    3'b111:  alu_ctrl = ALU_CTRL_BGEU;
                    default: illegal  = 1'b1;
                endcase
            end
            ALU_OP_ARITH_LOGIC: begin
                case (funct3)
                    // R-type SUB needs op_bit5; ADDI ignores funct7.
                    3'b000: alu_ctrl = (op_bit5 && funct7[5]) ? ALU_CTRL_SUB : ALU_CTRL_ADD_ADDI;
                    3'b001: alu_ctrl = ALU_CTRL_SLL_SLLI;
                    3'b010: alu_ctrl = ALU_CTRL_SLT_SLTI;
                    3'b011: alu_ctrl = ALU_CTRL_SLTU_SLTIU;
                    3'b100: alu_ctrl = ALU_CTRL_XOR_XORI;
                    // Register shifts use funct7[5]; immediate shifts use imm[10].
                    3'b101: alu_ctrl = ((op_bit5 && !funct7[5]) || (!op_bit5 && !imm_bit10))
                                       ? ALU_CTRL_SRL_SRLI : ALU_CTRL_SRA_SRAI;
                    3'b110: alu_ctrl = ALU_CTRL_OR_ORI;
                    3'b111: alu_ctrl = ALU_CTRL_AND_ANDI;
                endcase
`ifdef RV_ZBB_EN
                // Zbb register forms override the base decode.
                if (op_bit5 && funct7 == 7'b0000101 && funct3[2]) begin
                    case (funct3[1:0])
                        2'b00: alu_ctrl = ALU_CTRL_MIN;
                        2'b01: alu_ctrl = ALU_CTRL_MINU;
                        2'b10: alu_ctrl = ALU_CTRL_MAX;
                        2'b11: alu_ctrl = ALU_CTRL_MAXU;
                    endcase
                end else if (op_bit5 && funct7 == 7'b0100000) begin
                    case (funct3)
                        3'b111:  alu_ctrl = ALU_CTRL_ANDN;
                        3'b110:  alu_ctrl = ALU_CTRL_ORN;
                        3'b100:  alu_ctrl = ALU_CTRL_XNOR;
                        default: ;
                    endcase
                end
`endif
            end
            ALU_OP_AMO: begin
                case (amoop)
                    AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC: alu_ctrl = ALU_CTRL_ADD_ADDI;
                    AMO_XOR:  alu_ctrl = ALU_CTRL_XOR_XORI;
                    AMO_AND:  alu_ctrl = ALU_CTRL_AND_ANDI;
                    AMO_OR:   alu_ctrl = ALU_CTRL_OR_ORI;
                    AMO_MIN:  alu_ctrl = ALU_CTRL_MIN;
                    AMO_MAX:  alu_ctrl = ALU_CTRL_MAX;
                    AMO_MINU: alu_ctrl = ALU_CTRL_MINU;
                    AMO_MAXU: alu_ctrl = ALU_CTRL_MAXU;
                    default:  illegal  = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_decode_queue.sv
// ALU decode queue: decodes each request combinationally on the way in and
// stores the result in a DEPTH-entry FIFO, so an empty queue presents the
// decoded entry one cycle after the push.
// Ports: clk, resetn (async, active-low), flush (sync clear),
//        in_valid/in_ready + in_* request fields and in_tag,
//        out_valid/out_ready + out_alu_ctrl/out_illegal/out_tag,
//        illegal_cnt (saturating count of accepted illegal decodes).
// Macro: RV_ZBB_EN enables the Zbb decodes in the decoder core.
module alu_decode_queue
    import alu_decode_queue_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int TAG_WIDTH = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ALU_OP_WIDTH-1:0]   in_aluop,
    input  logic [AMO_OP_WIDTH-1:0]   in_amoop,
    input  logic [2:0]                in_funct3,
    input  logic [6:0]                in_funct7,
    input  logic                      in_op_bit5,
    input  logic                      in_imm_bit10,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ALU_CTRL_WIDTH-1:0] out_alu_ctrl,
    output logic                      out_illegal,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic [CNT_WIDTH-1:0]      illegal_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int QCNT_W = PTR_W + 1;
    localparam logic [QCNT_W-1:0] FULL = QCNT_W'(DEPTH);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]      tag;
        logic                      illegal;
        logic [ALU_CTRL_WIDTH-1:0] ctrl;
    } entry_t;

    entry_t                    mem [DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [QCNT_W-1:0]         count;
    logic [ALU_CTRL_WIDTH-1:0] dec_ctrl;
    logic                      dec_illegal;
    logic                      push;
    logic                      pop;

    alu_decode_queue_core u_core (
        .aluop     (in_aluop),
        .amoop     (in_amoop),
        .funct3    (in_funct3),
        .funct7    (in_funct7),
        .op_bit5   (in_op_bit5),
        .imm_bit10 (in_imm_bit10),
        .alu_ctrl  (dec_ctrl),
        .illegal   (dec_illegal)
    );

    // in_ready ignores out_ready: a full queue never pushes, even while popping.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + QCNT_W'(1);
                2'b01:   count <= count - QCNT_W'(1);
                default: ;
            endcase
        end
    end

    // push already excludes flush cycles, so a flushed illegal request is not counted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            illegal_cnt <= '0;
        end else if (push && dec_illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_WIDTH'(1);
        end
    end

    // Entry storage is not reset; out_* is only meaningful while out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{tag: in_tag, illegal: dec_illegal, ctrl: dec_ctrl};
        end
    end

    assign out_alu_ctrl = mem[rd_ptr].ctrl;
    assign out_illegal  = mem[rd_ptr].illegal;
    assign out_tag      = mem[rd_ptr].tag;

endmodule
